// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: default data width, signed max helper,
// counter width helper and the row-position classification used by pooling.
package cnn_pkg;

   localparam int DATA_W_DEF = 16;

   // Wide enough for any pixel width in use; callers sign-extend in and truncate out.
   localparam int SMAX_W = 64;

   // Row position of the current pixel inside its pooling window.
   typedef enum logic [1:0] {
      ROW_FIRST,
      ROW_MID,
      ROW_LAST,
      ROW_SKIP
   } row_pos_e;

   function automatic int CNT_W(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic logic signed [SMAX_W-1:0] smax(
      input logic signed [SMAX_W-1:0] a,
      input logic signed [SMAX_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer for the max-pool stage: one partial vertical max per
// pooling column group. One write port, one combinational read port on the
// same index. Storage is not reset.
module pool_line_buffer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2,
   parameter int AW     = 1
) (
   input  logic              clk1,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // Rounded up to a power of two so every index value addresses a real entry.
   logic [DATA_W-1:0] mem [2**AW];

   // Write the partial window maximum for the addressed group.
   always_ff @(posedge clk1) begin
      if (we) mem[idx] <= wdata;
   end

   // Combinational read of the same group.
   always_comb begin
      rdata = mem[idx];
   end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max-pool with stride POOL over a raster-ordered,
// channel-after-channel conv output stream. Optional output ReLU is enabled
// by defining the macro RELU_EN.
module maxpool_stream
   import cnn_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int OFM_SIZE = 4,
   parameter int POOL     = 2,
   parameter int CO       = 4
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              pool_done
);

   localparam int NG  = OFM_SIZE / POOL;
   localparam int UE  = NG * POOL;
   localparam int CW  = CNT_W(OFM_SIZE);
   localparam int CHW = CNT_W(CO);
   localparam int JW  = (NG > 1) ? $clog2(NG) : 1;

   localparam logic [CW-1:0]  OFM_LAST  = CW'(OFM_SIZE - 1);
   localparam logic [CW-1:0]  UE_C      = CW'(UE);
   localparam logic [CW-1:0]  UE_LAST   = CW'(UE - 1);
   localparam logic [CW-1:0]  POOL_C    = CW'(POOL);
   localparam logic [CW-1:0]  POOL_LAST = CW'(POOL - 1);
   localparam logic [CHW-1:0] CO_LAST   = CHW'(CO - 1);
   localparam logic [JW-1:0]  J_LAST    = JW'(NG - 1);

   logic [CW-1:0]  col, row;
   logic [CHW-1:0] ch;
   logic [CW-1:0]  eff_col, eff_row, cmod, rmod;
   logic [CHW-1:0] eff_ch;
   logic [JW-1:0]  j;

   logic signed [DATA_W-1:0] px, hmax, h, lb_rdata, result, lb_wdata;
   logic [DATA_W-1:0]        lb_rd_raw;
   row_pos_e                 rpos;
   logic                     group_end, lb_we, emit, frame_end;

   pool_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (NG),
      .AW     (JW)
   ) u_lbuf (
      .clk1   (clk1),
      .we     (lb_we),
      .idx    (j),
      .wdata  (lb_wdata),
      .rdata  (lb_rd_raw)
   );

   // Position decode and window compare/select; frame_start makes this pixel
   // position 0 of a new frame, so decode works on the effective counters.
   always_comb begin
      px        = in_data;
      lb_rdata  = lb_rd_raw;
      eff_col   = frame_start ? '0 : col;
      eff_row   = frame_start ? '0 : row;
      eff_ch    = frame_start ? '0 : ch;
      cmod      = eff_col % POOL_C;
      rmod      = eff_row % POOL_C;
      j         = JW'(eff_col / POOL_C);
      group_end = in_valid && (cmod == POOL_LAST) && (eff_col < UE_C);
      h         = DATA_W'(smax(SMAX_W'(hmax), SMAX_W'(px)));
      if (eff_row >= UE_C)        rpos = ROW_SKIP;
      else if (rmod == '0)        rpos = ROW_FIRST;
      else if (rmod == POOL_LAST) rpos = ROW_LAST;
      else                        rpos = ROW_MID;
      result    = DATA_W'(smax(SMAX_W'(lb_rdata), SMAX_W'(h)));
      lb_we     = group_end && ((rpos == ROW_FIRST) || (rpos == ROW_MID));
      lb_wdata  = (rpos == ROW_FIRST) ? h : result;
      emit      = group_end && (rpos == ROW_LAST);
      frame_end = in_valid && (eff_col == OFM_LAST) && (eff_row == OFM_LAST)
                  && (eff_ch == CO_LAST);
   end

   // Raster counters: col, then row, then channel; frame_start clears them.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
         ch  <= '0;
      end else if (in_valid) begin
         if (eff_col == OFM_LAST) begin
            col <= '0;
            if (eff_row == OFM_LAST) begin
               row <= '0;
               ch  <= (eff_ch == CO_LAST) ? '0 : eff_ch + 1'b1;
            end else begin
               row <= eff_row + 1'b1;
               ch  <= eff_ch;
            end
         end else begin
            col <= eff_col + 1'b1;
            row <= eff_row;
            ch  <= eff_ch;
         end
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
         ch  <= '0;
      end
   end

   // Horizontal max across the current column group.
   always_ff @(posedge clk1) begin
      if (in_valid) hmax <= (cmod == '0) ? px : h;
   end

   // Registered pooled output, window-end markers and frame-done pulse.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         pool_done <= 1'b0;
      end else begin
         out_valid <= emit;
         out_last  <= emit && (j == J_LAST) && (eff_row == UE_LAST);
         pool_done <= frame_end;
         if (emit) begin
`ifdef RELU_EN
            out_data <= result[DATA_W-1] ? '0 : result;
`else
            out_data <= result;
`endif
         end
      end
   end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: three instances (4x4/CO=1, 5x5/CO=1, 4x4/CO=4),
// expected pooled pixels computed from the input map and queued per window.
module tb_maxpool_stream;

   localparam int DW = 16;
   localparam int P  = 2;

   typedef struct {
      logic signed [DW-1:0] d;
      logic                 l;
   } exp_t;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic [2:0]        fs, iv, ov, ol, pd;
   logic [DW-1:0]     din  [3];
   logic [DW-1:0]     dout [3];

   int   n_vec = 0;
   int   n_err = 0;
   int   n_out = 0;
   int   n_last = 0;
   int   map [25];
   exp_t exp_q [$];
   string cur;

   always #5 clk1 = ~clk1;

   maxpool_stream #(.DATA_W(DW), .OFM_SIZE(4), .POOL(P), .CO(1)) u_a (
      .clk1(clk1), .rst_n(rst_n), .frame_start(fs[0]), .in_valid(iv[0]),
      .in_data(din[0]), .out_valid(ov[0]), .out_data(dout[0]),
      .out_last(ol[0]), .pool_done(pd[0]));

   maxpool_stream #(.DATA_W(DW), .OFM_SIZE(5), .POOL(P), .CO(1)) u_b (
      .clk1(clk1), .rst_n(rst_n), .frame_start(fs[1]), .in_valid(iv[1]),
      .in_data(din[1]), .out_valid(ov[1]), .out_data(dout[1]),
      .out_last(ol[1]), .pool_done(pd[1]));

   maxpool_stream #(.DATA_W(DW), .OFM_SIZE(4), .POOL(P), .CO(4)) u_c (
      .clk1(clk1), .rst_n(rst_n), .frame_start(fs[2]), .in_valid(iv[2]),
      .in_data(din[2]), .out_valid(ov[2]), .out_data(dout[2]),
      .out_last(ol[2]), .pool_done(pd[2]));

   function automatic int pix(input int r, input int c, input int ch, input int ofm);
      return map[r*ofm + c] + ch * 7;
   endfunction

   function automatic int win_max(input int wr, input int wc, input int ch, input int ofm);
      int m;
      m = pix(wr*P, wc*P, ch, ofm);
      for (int r = 0; r < P; r++)
         for (int c = 0; c < P; c++)
            if (pix(wr*P + r, wc*P + c, ch, ofm) > m) m = pix(wr*P + r, wc*P + c, ch, ofm);
      return m;
   endfunction

   function automatic int relu(input int v);
`ifdef RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // One clock on instance s; checks pooled output and pool_done right after the edge.
   task automatic cycle(input int s, input logic v, input logic f, input int d,
                        input logic exp_done);
      exp_t e;
      iv[s]  = v;
      fs[s]  = f;
      din[s] = DW'(d);
      @(posedge clk1);
      #1;
      iv[s] = 1'b0;
      fs[s] = 1'b0;
      if (ov[s] === 1'b1) n_out++;
      if (ov[s] === 1'b1 && ol[s] === 1'b1) n_last++;
      n_vec++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (ov[s] !== 1'b1 || dout[s] !== e.d || ol[s] !== e.l) begin
            n_err++;
            $display("FAIL %s out: valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                     cur, ov[s], $signed(dout[s]), ol[s], e.d, e.l);
         end
      end else if (ov[s] !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle: out_valid=%0b, required 0", cur, ov[s]);
      end
      n_vec++;
      if (pd[s] !== exp_done) begin
         n_err++;
         $display("FAIL %s pool_done: got %0b, required %0b", cur, pd[s], exp_done);
      end
   endtask

   task automatic send_frame(input int s, input int ofm, input int co,
                             input logic gaps, input logic fs_first);
      int   ue;
      exp_t e;
      ue = (ofm / P) * P;
      for (int ch = 0; ch < co; ch++)
         for (int r = 0; r < ofm; r++)
            for (int c = 0; c < ofm; c++) begin
               if (r % P == P-1 && c % P == P-1 && r < ue && c < ue) begin
                  e.d = DW'(relu(win_max(r/P, c/P, ch, ofm)));
                  e.l = (r == ue-1) && (c == ue-1);
                  exp_q.push_back(e);
               end
               cycle(s, 1'b1, fs_first && ch == 0 && r == 0 && c == 0, pix(r, c, ch, ofm),
                     r == ofm-1 && c == ofm-1 && ch == co-1);
               if (gaps) repeat ($urandom_range(0, 3)) cycle(s, 1'b0, 1'b0, 0, 1'b0);
            end
   endtask

   task automatic load_test1_map();
      int t [16] = '{1, 5, 3, 2, 4, 0, 7, -1, 0, 0, 0, 0, -3, -8, -2, -9};
      for (int i = 0; i < 16; i++) map[i] = t[i];
   endtask

   task automatic check_count(input string nm, input int got, input int req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s %s: got %0d, required %0d", cur, nm, got, req);
      end
   endtask

   task automatic test_reset();
      cur = "reset";
      rst_n = 1'b0;
      fs = '0;
      iv = '0;
      for (int i = 0; i < 3; i++) din[i] = '0;
      #3;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (ov[i] !== 1'b0 || dout[i] !== '0 || ol[i] !== 1'b0 || pd[i] !== 1'b0) begin
            n_err++;
            $display("FAIL reset inst%0d: valid=%0b data=%0d last=%0b done=%0b, required all 0",
                     i, ov[i], dout[i], ol[i], pd[i]);
         end
      end
      repeat (2) @(posedge clk1);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      cur = "basic";
      load_test1_map();
      n_out = 0;
      n_last = 0;
      send_frame(0, 4, 1, 1'b0, 1'b0);
      cycle(0, 1'b0, 1'b0, 0, 1'b0);
      check_count("outputs", n_out, 4);
      check_count("out_last", n_last, 1);
   endtask

   task automatic test_gaps();
      cur = "gaps";
      load_test1_map();
      send_frame(0, 4, 1, 1'b1, 1'b0);
   endtask

   task automatic test_negative();
      cur = "negative";
      for (int i = 0; i < 16; i++) map[i] = -5 - i;
      send_frame(0, 4, 1, 1'b0, 1'b0);
   endtask

   task automatic test_odd_size();
      cur = "odd_size";
      for (int i = 0; i < 25; i++) map[i] = (i * 13) % 29 - 10;
      n_out = 0;
      send_frame(1, 5, 1, 1'b0, 1'b0);
      check_count("outputs", n_out, 4);
   endtask

   task automatic test_frame_start();
      exp_t e;
      cur = "frame_start";
      for (int i = 0; i < 16; i++) map[i] = 100 + i;
      for (int c = 0; c < 4; c++) cycle(0, 1'b1, 1'b0, pix(0, c, 0, 4), 1'b0);
      e.d = DW'(relu(win_max(0, 0, 0, 4)));
      e.l = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) exp_q.push_back(e);
         cycle(0, 1'b1, 1'b0, pix(1, c, 0, 4), 1'b0);
      end
      load_test1_map();
      send_frame(0, 4, 1, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      exp_t e;
      cur = "async_reset";
      for (int i = 0; i < 16; i++) map[i] = 3 * i - 20;
      for (int c = 0; c < 4; c++) cycle(2, 1'b1, 1'b0, pix(0, c, 0, 4), 1'b0);
      e.d = DW'(relu(win_max(0, 0, 0, 4)));
      e.l = 1'b0;
      cycle(2, 1'b1, 1'b0, pix(1, 0, 0, 4), 1'b0);
      exp_q.push_back(e);
      cycle(2, 1'b1, 1'b0, pix(1, 1, 0, 4), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (ov[2] !== 1'b0 || dout[2] !== '0 || ol[2] !== 1'b0 || pd[2] !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset hold%0d: valid=%0b data=%0d last=%0b done=%0b, required all 0",
                     k, ov[2], dout[2], ol[2], pd[2]);
         end
         iv[2]  = 1'b1;
         din[2] = DW'(77);
         @(posedge clk1);
         #1;
      end
      iv[2] = 1'b0;
      rst_n = 1'b1;
      exp_q.delete();
      n_last = 0;
      send_frame(2, 4, 4, 1'b0, 1'b0);
      check_count("out_last", n_last, 4);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_negative();
      test_odd_size();
      test_frame_start();
      test_async_reset();
      repeat (2) @(posedge clk1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
